// File: rtl/imm_extend_pipe.sv
// rtl/imm_extend_pipe.sv - handshaked immediate/offset sign/zero extension with optional fixed left shift
// Registered output plus one-entry skid buffer; in_ready depends only on skid occupancy.
module imm_extend_pipe #(
  parameter int IN_W  = 3,
  parameter int OUT_W = 8,
  parameter int SHAMT = 1
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [IN_W-1:0]  in_offset,
  input  logic [1:0]       in_mode,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [OUT_W-1:0] out_val,
  output logic             out_trunc,
  output logic [15:0]      xfer_count
);

  // Full-precision width: an OUT_W-bit extended value shifted left by SHAMT never overflows W bits.
  localparam int W = OUT_W + SHAMT;
  localparam logic [W-1:0] HI_MASK = ~((W'(1) << IN_W) - W'(1));

  logic             mode_zero;
  logic             mode_shift;
  logic [W-1:0]     ext_w;
  logic [W-1:0]     full_w;
  logic [OUT_W-1:0] new_val;
  logic             new_trunc;

  logic             or_valid;
  logic [OUT_W-1:0] or_val;
  logic             or_trunc;
  logic             sk_full;
  logic [OUT_W-1:0] sk_val;
  logic             sk_trunc;
  logic [15:0]      cnt;

  logic accept;
  logic drain;

  assign mode_zero  = in_mode[0];
  assign mode_shift = in_mode[1];

  always_comb begin
    ext_w = W'(in_offset);
    if (!mode_zero && in_offset[IN_W-1]) begin
      ext_w = ext_w | HI_MASK;
    end
    full_w = ext_w << SHAMT;
    new_val = mode_shift ? full_w[OUT_W-1:0] : ext_w[OUT_W-1:0];
    // Bits above OUT_W-1 must be zero (unsigned) or copies of the result's sign bit (signed).
    new_trunc = 1'b0;
    for (int i = OUT_W; i < W; i++) begin
      if (mode_zero) begin
        new_trunc = new_trunc | full_w[i];
      end else begin
        new_trunc = new_trunc | (full_w[i] ^ full_w[OUT_W-1]);
      end
    end
    if (!mode_shift) begin
      new_trunc = 1'b0;
    end
  end

  assign accept = in_valid && !sk_full;
  assign drain  = or_valid && out_ready;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      or_valid <= 1'b0;
      or_val   <= '0;
      or_trunc <= 1'b0;
      sk_full  <= 1'b0;
      sk_val   <= '0;
      sk_trunc <= 1'b0;
      cnt      <= 16'd0;
    end else begin
      if (drain) begin
        cnt <= cnt + 16'd1;
        if (sk_full) begin
          // accept is impossible here since in_ready was low
          or_val   <= sk_val;
          or_trunc <= sk_trunc;
          sk_full  <= 1'b0;
        end else if (accept) begin
          or_val   <= new_val;
          or_trunc <= new_trunc;
        end else begin
          or_valid <= 1'b0;
        end
      end else if (accept) begin
        if (!or_valid) begin
          or_valid <= 1'b1;
          or_val   <= new_val;
          or_trunc <= new_trunc;
        end else begin
          sk_full  <= 1'b1;
          sk_val   <= new_val;
          sk_trunc <= new_trunc;
        end
      end
    end
  end

  assign in_ready   = !sk_full;
  assign out_valid  = or_valid;
  assign out_val    = or_val;
  assign out_trunc  = or_trunc;
  assign xfer_count = cnt;

endmodule

// File: tb/tb_imm_extend_pipe.sv
// tb/tb_imm_extend_pipe.sv - randomized self-checking bench for imm_extend_pipe against an arithmetic model
module tb_imm_extend_pipe;

  logic        clk = 1'b0;
  logic        rst;
  logic        in_valid, in_ready, out_valid, out_ready, out_trunc;
  logic [2:0]  in_offset;
  logic [1:0]  in_mode;
  logic [7:0]  out_val;
  logic [15:0] xfer_count;

  logic        in_valid_t, in_ready_t, out_valid_t, out_ready_t, out_trunc_t;
  logic [2:0]  in_offset_t;
  logic [1:0]  in_mode_t;
  logic [3:0]  out_val_t;
  logic [15:0] xfer_count_t;

  int          n_checks = 0;
  int          n_errors = 0;
  logic [8:0]  sb[$];
  logic [15:0] tally = 16'd0;
  logic        hold_pend = 1'b0;
  logic [8:0]  hold_data = 9'd0;

  always #5 clk = ~clk;

  imm_extend_pipe #(.IN_W(3), .OUT_W(8), .SHAMT(1)) dut (
    .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready),
    .in_offset(in_offset), .in_mode(in_mode), .out_valid(out_valid),
    .out_ready(out_ready), .out_val(out_val), .out_trunc(out_trunc),
    .xfer_count(xfer_count)
  );

  imm_extend_pipe #(.IN_W(3), .OUT_W(4), .SHAMT(2)) dut_t (
    .clk(clk), .rst(rst), .in_valid(in_valid_t), .in_ready(in_ready_t),
    .in_offset(in_offset_t), .in_mode(in_mode_t), .out_valid(out_valid_t),
    .out_ready(out_ready_t), .out_val(out_val_t), .out_trunc(out_trunc_t),
    .xfer_count(xfer_count_t)
  );

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    if (obs !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
    end
  endtask

  // Exact integer value of the field, scaled, then range-checked; result is {trunc, low OUT_W bits}.
  function automatic logic [8:0] model(input int iw, input int ow, input int sh,
                                       input int off, input int mode);
    longint v;
    longint m;
    logic   tr;
    v = off;
    if ((mode & 1) == 0 && off >= (1 << (iw - 1))) v = off - (1 << iw);
    if ((mode & 2) != 0) v = v * (64'sd1 << sh);
    if ((mode & 1) != 0) tr = (v > (64'sd1 << ow) - 1);
    else tr = (v < -(64'sd1 << (ow - 1))) || (v > (64'sd1 << (ow - 1)) - 1);
    m = v & ((64'sd1 << ow) - 1);
    return {tr, m[7:0]};
  endfunction

  always @(negedge clk) begin
    if (!rst) begin
      if (hold_pend) begin
        chk("hold_valid", {31'd0, out_valid}, 32'd1);
        chk("hold_data", {23'd0, out_trunc, out_val}, {23'd0, hold_data});
      end
      if (in_valid && in_ready) sb.push_back(model(3, 8, 1, in_offset, in_mode));
      if (out_valid && out_ready) begin
        chk("sb_nonempty", {31'd0, sb.size() > 0}, 32'd1);
        if (sb.size() > 0) chk("data", {23'd0, out_trunc, out_val}, {23'd0, sb.pop_front()});
        tally = tally + 16'd1;
      end
      hold_pend = out_valid && !out_ready;
      hold_data = {out_trunc, out_val};
    end else begin
      hold_pend = 1'b0;
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic push(input int off, input int mode);
    int g;
    in_valid  = 1'b1;
    in_offset = off[2:0];
    in_mode   = mode[1:0];
    g = 0;
    while (!in_ready && g < 50) begin
      tick();
      g++;
    end
    chk("push_ready", {31'd0, in_ready}, 32'd1);
    tick();
  endtask

  task automatic push_t(input int off, input int mode);
    logic [8:0] m;
    in_valid_t  = 1'b1;
    in_offset_t = off[2:0];
    in_mode_t   = mode[1:0];
    tick();
    in_valid_t  = 1'b0;
    m = model(3, 4, 2, off, mode);
    chk("t_valid", {31'd0, out_valid_t}, 32'd1);
    chk("t_val", {28'd0, out_val_t}, {28'd0, m[3:0]});
    chk("t_trunc", {31'd0, out_trunc_t}, {31'd0, m[8]});
  endtask

  initial begin
    int t0;
    int g;
    rst = 1'b1;
    in_valid = 1'b0; in_offset = 3'd0; in_mode = 2'd0; out_ready = 1'b0;
    in_valid_t = 1'b0; in_offset_t = 3'd0; in_mode_t = 2'd0; out_ready_t = 1'b1;
    #1;
    chk("rst_out_valid", {31'd0, out_valid}, 32'd0);
    chk("rst_in_ready", {31'd0, in_ready}, 32'd1);
    chk("rst_out_val", {24'd0, out_val}, 32'd0);
    chk("rst_out_trunc", {31'd0, out_trunc}, 32'd0);
    chk("rst_xfer_count", {16'd0, xfer_count}, 32'd0);
    tick(); tick();
    rst = 1'b0;

    // mode sweep
    out_ready = 1'b1;
    push(5, 0); chk("sweep0", {23'd0, out_trunc, out_val}, 32'h0FD);
    push(5, 1); chk("sweep1", {23'd0, out_trunc, out_val}, 32'h005);
    push(5, 2); chk("sweep2", {23'd0, out_trunc, out_val}, 32'h0FA);
    push(5, 3); chk("sweep3", {23'd0, out_trunc, out_val}, 32'h00A);
    in_valid = 1'b0;
    tick();
    chk("sweep_count", {16'd0, xfer_count}, 32'd4);

    // truncation on the narrow instance
    push_t(3, 2);
    push_t(7, 2);
    push_t(3, 3);
    push_t(7, 3);
    push_t(4, 2);

    // backpressure
    out_ready = 1'b0;
    push(0, 0);
    push(1, 0);
    chk("bp_in_ready", {31'd0, in_ready}, 32'd0);
    chk("bp_or", {24'd0, out_val}, 32'h00);
    in_offset = 3'd2;
    repeat (3) begin
      tick();
      chk("bp_stall_ready", {31'd0, in_ready}, 32'd0);
      chk("bp_stall_val", {24'd0, out_val}, 32'h00);
    end
    out_ready = 1'b1;
    push(2, 0);
    push(3, 0);
    in_valid = 1'b0;
    repeat (3) tick();
    chk("bp_drained", {31'd0, out_valid}, 32'd0);

    // full throughput
    t0 = tally;
    in_valid = 1'b1;
    for (int i = 0; i < 100; i++) begin
      in_offset = 3'($urandom);
      in_mode   = 2'($urandom);
      tick();
    end
    in_valid = 1'b0;
    tick();
    chk("thru_count", 32'(tally) - 32'(t0), 32'd100);
    chk("thru_xfer", {16'd0, xfer_count}, {16'd0, tally});

    // random handshakes
    for (int i = 0; i < 400; i++) begin
      in_valid  = 1'($urandom);
      out_ready = 1'($urandom);
      in_offset = 3'($urandom);
      in_mode   = 2'($urandom);
      tick();
    end
    in_valid = 1'b0;
    out_ready = 1'b1;
    repeat (3) tick();
    chk("rand_empty", sb.size(), 32'd0);
    chk("rand_xfer", {16'd0, xfer_count}, {16'd0, tally});

    // reset while both registers are full
    out_ready = 1'b0;
    push(1, 0);
    push(2, 1);
    in_valid = 1'b0;
    chk("pre_rst_full", {31'd0, in_ready}, 32'd0);
    #2 rst = 1'b1;
    #1;
    chk("mid_rst_out_valid", {31'd0, out_valid}, 32'd0);
    chk("mid_rst_in_ready", {31'd0, in_ready}, 32'd1);
    chk("mid_rst_xfer", {16'd0, xfer_count}, 32'd0);
    sb.delete();
    tally = 16'd0;
    tick();
    rst = 1'b0;
    out_ready = 1'b1;
    push(6, 0);
    in_valid = 1'b0;
    chk("post_rst_valid", {31'd0, out_valid}, 32'd1);
    chk("post_rst_val", {23'd0, out_trunc, out_val}, 32'h0FE);
    tick();
    chk("post_rst_empty", {31'd0, out_valid}, 32'd0);

    // counter wrap
    in_valid = 1'b1;
    g = 0;
    while (tally != 16'hFFFF && g < 70000) begin
      in_offset = 3'($urandom);
      in_mode   = 2'($urandom);
      tick();
      g++;
    end
    in_valid = 1'b0;
    out_ready = 1'b0;
    chk("wrap_reached", {16'd0, tally}, 32'hFFFF);
    chk("wrap_pre", {16'd0, xfer_count}, 32'hFFFF);
    out_ready = 1'b1;
    tick();
    chk("wrap_post", {16'd0, xfer_count}, 32'h0000);

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
